local_store_copier: RTL and testbench

Block-copy engine that moves a run of 128-bit quadwords from one region of the SPU data memory to another. It drives the data memory's request side (`address`, `writeData`, `memWrite`, `memRead`) and consumes its registered `readData`. It sits beside the load/store path and is granted the memory port whenever `busy` is high. Copies with overlapping source and destination regions behave as a move: the destination always ends up holding the original source contents.

---
 rtl/local_store_copier_if.sv | 27 ++
 rtl/local_store_copier.sv | 142 ++++++++++++++
 tb/tb_local_store_copier.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/local_store_copier_if.sv
// Request/response bundle between the block-copy engine and the SPU data memory,
// plus the copy command and status lines.
interface local_store_copier_if #(
    parameter int LEN_W = 12
);
    logic             start;
    logic [31:0]      srcAddr;
    logic [31:0]      dstAddr;
    logic [LEN_W-1:0] length;
    logic [127:0]     readData;
    logic [127:0]     address;
    logic [127:0]     writeData;
    logic             memWrite;
    logic             memRead;
    logic             busy;
    logic             done;

    modport master (
        input  start, srcAddr, dstAddr, length, readData,
        output address, writeData, memWrite, memRead, busy, done
    );

    modport slave (
        output start, srcAddr, dstAddr, length, readData,
        input  address, writeData, memWrite, memRead, busy, done
    );
endinterface

// File: rtl/local_store_copier.sv
// Quadword block-copy engine: alternates READ/WRITE cycles on the data memory port,
// walking downwards when the destination overlaps the top of the source (move semantics).
module local_store_copier #(
    parameter int LEN_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    local_store_copier_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_src_ptr;
    logic [31:0]      r_dst_ptr;
    logic [LEN_W-1:0] r_cnt;
    logic             r_desc;

    logic [31:0]  w_src_al;
    logic [31:0]  w_dst_al;
    logic [31:0]  w_len_bytes;
    logic [31:0]  w_last_off;
    logic [32:0]  w_src_end;
    logic         w_desc;
    logic [127:0] w_address;
    logic [127:0] w_write_data;
    logic         w_mem_read;
    logic         w_mem_write;
    logic         w_busy;
    logic         w_done;

    assign w_src_al    = {bus.srcAddr[31:4], 4'h0};
    assign w_dst_al    = {bus.dstAddr[31:4], 4'h0};
    assign w_len_bytes = 32'(bus.length) << 3'd4;
    assign w_last_off  = w_len_bytes - 32'd16;
    // 33-bit end bound so a region ending at the top of the address space cannot wrap
    assign w_src_end   = {1'b0, w_src_al} + {1'b0, w_len_bytes};
    assign w_desc      = (w_dst_al > w_src_al) && ({1'b0, w_dst_al} < w_src_end);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Pointer, count and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr <= 32'd0;
            r_dst_ptr <= 32'd0;
            r_cnt     <= '0;
            r_desc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_src_ptr <= w_desc ? (w_src_al + w_last_off) : w_src_al;
                        r_dst_ptr <= w_desc ? (w_dst_al + w_last_off) : w_dst_al;
                        r_cnt     <= bus.length;
                        r_desc    <= w_desc;
                    end
                end
                S_WRITE: begin
                    r_src_ptr <= r_desc ? (r_src_ptr - 32'd16) : (r_src_ptr + 32'd16);
                    r_dst_ptr <= r_desc ? (r_dst_ptr - 32'd16) : (r_dst_ptr + 32'd16);
                    r_cnt     <= r_cnt - LEN_W'(1'b1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.length == '0) ? S_DONE : S_READ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ:  w_next = S_WRITE;
            S_WRITE: begin
                if (r_cnt == LEN_W'(1'b1)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_READ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; writeData forwards the memory's registered read of the previous cycle
    always_comb begin
        w_address    = 128'd0;
        w_write_data = 128'd0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_READ: begin
                w_address  = {96'd0, r_src_ptr};
                w_mem_read = 1'b1;
                w_busy     = 1'b1;
            end
            S_WRITE: begin
                w_address    = {96'd0, r_dst_ptr};
                w_write_data = bus.readData;
                w_mem_write  = 1'b1;
                w_busy       = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    assign bus.address   = w_address;
    assign bus.writeData = w_write_data;
    assign bus.memRead   = w_mem_read;
    assign bus.memWrite  = w_mem_write;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_local_store_copier.sv
// Directed bench for local_store_copier: behavioural data memory, write scoreboard,
// and cycle-accurate checks of strobes, busy and done.
module tb_local_store_copier;
    logic clk;
    logic reset;

    local_store_copier_if #(.LEN_W(12)) bus ();

    local_store_copier #(.LEN_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] mem  [0:2000];
    logic [127:0] snap [0:2000];

    typedef struct {
        logic [31:0]  a;
        logic [127:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Data memory with registered read port
    always @(posedge clk) begin
        if (reset) begin
            bus.readData <= 128'd0;
        end else if (bus.memRead) begin
            bus.readData <= mem[bus.address[14:4]];
        end
        if (bus.memWrite) begin
            mem[bus.address[14:4]] <= bus.writeData;
        end
    end

    // Scoreboard: every memory write must match the next expected (address, data)
    always @(negedge clk) begin
        wr_t e;
        if (bus.memWrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", bus.address, 128'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.address, {96'd0, e.a});
                check("write_data", bus.writeData, e.d);
            end
        end
    end

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int hold, input logic [31:0] exp_r0, input logic [31:0] exp_w0);
        longint s, d;
        bit desc;
        int idx;
        int done_cyc, done_cnt, busy_cnt, rd_cnt, wr_cnt, both_cnt;
        logic [127:0] first_r, first_w;
        for (int i = 0; i <= 2000; i++) snap[i] = mem[i];
        s = longint'(src & 32'hFFFF_FFF0);
        d = longint'(dst & 32'hFFFF_FFF0);
        desc = (d > s) && (d < s + 16 * len);
        for (int i = 0; i < len; i++) begin
            idx = desc ? (len - 1 - i) : i;
            exp_q.push_back('{a: 32'(d + 16 * idx), d: snap[int'(s >> 4) + idx]});
        end
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        first_r = '1; first_w = '1;
        @(negedge clk);
        bus.start = 1'b1; bus.srcAddr = src; bus.dstAddr = dst; bus.length = 12'(len);
        @(posedge clk);
        #1;
        if (hold == 0) begin
            bus.start = 1'b0;
        end else begin
            bus.srcAddr = 32'h20; bus.dstAddr = 32'h380; bus.length = 12'd3;
        end
        for (int c = 1; c <= 2 * len + 8; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (bus.busy) busy_cnt++;
            if (bus.memRead) begin
                if (rd_cnt == 0) first_r = bus.address;
                rd_cnt++;
            end
            if (bus.memWrite) begin
                if (wr_cnt == 0) first_w = bus.address;
                wr_cnt++;
            end
            if (bus.memRead && bus.memWrite) both_cnt++;
            if (c == hold) bus.start = 1'b0;
        end
        check("done_cycle", 128'(done_cyc), 128'(2 * len + 1));
        check("done_pulses", 128'(done_cnt), 128'd1);
        check("busy_cycles", 128'(busy_cnt), 128'(2 * len));
        check("read_strobes", 128'(rd_cnt), 128'(len));
        check("write_strobes", 128'(wr_cnt), 128'(len));
        check("rd_wr_overlap", 128'(both_cnt), 128'd0);
        if (len > 0) begin
            check("first_read_addr", first_r, {96'd0, exp_r0});
            check("first_write_addr", first_w, {96'd0, exp_w0});
        end
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int dn, st;
        for (int i = 0; i <= 2000; i++) mem[i] <= 128'd0;
        reset = 1'b1;
        bus.start = 1'b0; bus.srcAddr = 32'd0; bus.dstAddr = 32'd0; bus.length = 12'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_address", bus.address, 128'd0);
        check("rst_writeData", bus.writeData, 128'd0);
        check("rst_memRead", 128'(bus.memRead), 128'd0);
        check("rst_memWrite", 128'(bus.memWrite), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        reset = 1'b0;

        // Ascending copy
        mem[0] <= 128'hA; mem[1] <= 128'hB; mem[2] <= 128'hC;
        @(negedge clk);
        run_copy(32'h000, 32'h100, 3, 0, 32'h000, 32'h100);
        @(negedge clk);
        check("asc_q0", mem[16'h10], 128'hA);
        check("asc_q1", mem[16'h11], 128'hB);
        check("asc_q2", mem[16'h12], 128'hC);

        // Overlapping move, walks downwards
        mem[0] <= 128'd1; mem[1] <= 128'd2; mem[2] <= 128'd3; mem[3] <= 128'd4;
        @(negedge clk);
        run_copy(32'h000, 32'h010, 4, 0, 32'h030, 32'h040);
        @(negedge clk);
        check("move_q0", mem[1], 128'd1);
        check("move_q1", mem[2], 128'd2);
        check("move_q2", mem[3], 128'd3);
        check("move_q3", mem[4], 128'd4);

        // Unaligned addresses
        run_copy(32'h10F, 32'h20A, 1, 0, 32'h100, 32'h200);
        @(negedge clk);
        check("unaligned_data", mem[16'h20], 128'hA);

        // Zero length
        run_copy(32'h000, 32'h600, 0, 0, 32'h0, 32'h0);
        check("zero_len_mem", mem[16'h60], 128'd0);

        // Start held high with other arguments while busy
        run_copy(32'h000, 32'h300, 2, 4, 32'h000, 32'h300);
        @(negedge clk);
        check("busy_q0", mem[16'h30], 128'd1);
        check("busy_q1", mem[16'h31], 128'd1);
        check("busy_ignored", mem[16'h38], 128'd0);

        // Reset during the second write of a four-quadword copy
        for (int i = 0; i < 4; i++) begin
            mem[16'h40 + i] <= 128'h71 + 128'(i);
            mem[16'h50 + i] <= 128'hDEAD;
        end
        exp_q.push_back('{a: 32'h500, d: 128'h71});
        exp_q.push_back('{a: 32'h510, d: 128'h72});
        @(negedge clk);
        bus.start = 1'b1; bus.srcAddr = 32'h400; bus.dstAddr = 32'h500; bus.length = 12'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_in_write", 128'(bus.memWrite), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_address", bus.address, 128'd0);
        check("rst_mid_writeData", bus.writeData, 128'd0);
        check("rst_mid_memRead", 128'(bus.memRead), 128'd0);
        check("rst_mid_memWrite", 128'(bus.memWrite), 128'd0);
        check("rst_mid_busy", 128'(bus.busy), 128'd0);
        check("rst_mid_done", 128'(bus.done), 128'd0);
        reset = 1'b0;
        dn = 0; st = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.memRead || bus.memWrite) st++;
        end
        check("rst_mid_no_done", 128'(dn), 128'd0);
        check("rst_mid_no_strobe", 128'(st), 128'd0);
        check("rst_mid_q1", mem[16'h50], 128'h71);
        check("rst_mid_q3", mem[16'h52], 128'hDEAD);
        check("rst_mid_q4", mem[16'h53], 128'hDEAD);
        check("rst_mid_sb", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
